// File: rtl/interconnect_arbiter_if.sv
// Stream bus between N_CH requesting channels and the single arbitrated output.
interface interconnect_arbiter_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned CH_W = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]        in_valid;
  logic [N_CH-1:0]        in_ready;
  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic                   out_last;
  logic [CH_W-1:0]        out_ch;

  // Arbiter side
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_ch
  );

  // Traffic source / sink side
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_ch
  );
endinterface

// File: rtl/interconnect_arbiter.sv
// Packet-level arbiter: picks one channel per packet (round-robin or fixed
// priority), locks onto it until its last beat, and forwards beats through a
// single registered output stage.
module interconnect_arbiter #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  interconnect_arbiter_if.slave bus,
  output logic                  busy
);
  localparam int unsigned CH_W = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state_q;
  logic [CH_W-1:0]   grant_q;
  logic [CH_W-1:0]   rr_ptr_q;
  logic [CH_W-1:0]   rr_ptr_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic [CH_W-1:0]   out_ch_q;
  logic              busy_q;

  logic [CH_W-1:0]   winner_c;
  logic              accept_c;
  logic              xfer_c;
  logic              grant_last_c;
  logic [DATA_W-1:0] grant_data_c;

  // Winner search: upward from rr_ptr with wrap (MODE 0) or from ch0 (MODE 1)
  always_comb begin
    logic             found;
    logic [CH_W-1:0]  idx;
    winner_c = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (MODE == 0) begin
        idx = CH_W'((32'(rr_ptr_q) + i) % N_CH);
      end else begin
        idx = CH_W'(i);
      end
      if (!found && bus.in_valid[idx]) begin
        found    = 1'b1;
        winner_c = idx;
      end
    end
  end

  // Granted channel may push a beat when the output stage is empty or draining
  assign accept_c     = (state_q == LOCK) && (!out_valid_q || bus.out_ready) && !rst;
  assign xfer_c       = accept_c && bus.in_valid[grant_q];
  assign grant_last_c = bus.in_last[grant_q];
  assign grant_data_c = bus.in_data[32'(grant_q) * DATA_W +: DATA_W];

  // Pointer moves just past the channel whose packet is finishing
  assign rr_ptr_d = (grant_q == CH_W'(N_CH - 1)) ? '0 : grant_q + CH_W'(1);

  // Only the granted channel ever sees ready
  always_comb begin
    bus.in_ready = '0;
    if (accept_c) begin
      bus.in_ready[grant_q] = 1'b1;
    end
  end

  // Arbitration FSM and registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.in_valid) begin
            grant_q <= winner_c;
            state_q <= LOCK;
            busy_q  <= 1'b1;
          end
        end
        LOCK: begin
          if (xfer_c && grant_last_c) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (MODE == 0) begin
              rr_ptr_q <= rr_ptr_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (xfer_c) begin
        out_valid_q <= 1'b1;
        out_data_q  <= grant_data_c;
        out_last_q  <= grant_last_c;
        out_ch_q    <= grant_q;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ch    = out_ch_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_interconnect_arbiter.sv
// Scoreboard bench for interconnect_arbiter: one round-robin and one
// fixed-priority instance, selected one at a time through a small mux.
module tb_interconnect_arbiter;
  localparam int unsigned N_CH   = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CH_W   = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [CH_W-1:0]   ch;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   sel = 1'b0;
  logic [N_CH-1:0]        tb_in_valid = '0;
  logic [N_CH-1:0]        tb_in_last  = '0;
  logic [N_CH*DATA_W-1:0] tb_in_data  = '0;
  logic                   tb_out_ready = 1'b0;
  logic                   busy0, busy1;

  interconnect_arbiter_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus0 ();
  interconnect_arbiter_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus1 ();

  interconnect_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .bus(bus0.slave), .busy(busy0));
  interconnect_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .bus(bus1.slave), .busy(busy1));

  assign bus0.in_valid  = sel ? '0 : tb_in_valid;
  assign bus1.in_valid  = sel ? tb_in_valid : '0;
  assign bus0.in_data   = tb_in_data;
  assign bus1.in_data   = tb_in_data;
  assign bus0.in_last   = tb_in_last;
  assign bus1.in_last   = tb_in_last;
  assign bus0.out_ready = tb_out_ready;
  assign bus1.out_ready = tb_out_ready;

  logic [N_CH-1:0]   m_in_ready;
  logic              m_out_valid, m_out_last, m_busy;
  logic [DATA_W-1:0] m_out_data;
  logic [CH_W-1:0]   m_out_ch;
  assign m_in_ready  = sel ? bus1.in_ready  : bus0.in_ready;
  assign m_out_valid = sel ? bus1.out_valid : bus0.out_valid;
  assign m_out_data  = sel ? bus1.out_data  : bus0.out_data;
  assign m_out_last  = sel ? bus1.out_last  : bus0.out_last;
  assign m_out_ch    = sel ? bus1.out_ch    : bus0.out_ch;
  assign m_busy      = sel ? busy1 : busy0;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    model_rr = 0;
  beat_t exp_q[$];
  beat_t chq[N_CH][$];
  int    ch_log[$];
  int    cyc_log[$];
  beat_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every accepted output beat is compared with the scoreboard head
  always @(negedge clk) begin
    if (!rst && m_out_valid && tb_out_ready) begin
      ch_log.push_back(int'(m_out_ch));
      cyc_log.push_back(cyc);
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got ch=%0d data=%0h last=%0b, required no beat",
                 m_out_ch, m_out_data, m_out_last);
      end else begin
        mon_e = exp_q.pop_front();
        if ({m_out_data, m_out_last, m_out_ch} !== {mon_e.data, mon_e.last, mon_e.ch}) begin
          n_fail++;
          $display("FAIL sb_beat: got ch=%0d data=%0h last=%0b, required ch=%0d data=%0h last=%0b",
                   m_out_ch, m_out_data, m_out_last, mon_e.ch, mon_e.data, mon_e.last);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst          = 1'b1;
    tb_in_valid  = '0;
    tb_in_last   = '0;
    tb_in_data   = '0;
    tb_out_ready = 1'b0;
    tick;
    tick;
    rst      = 1'b0;
    model_rr = 0;
    ch_log.delete();
    cyc_log.delete();
  endtask

  task automatic drive(input int k, input logic [DATA_W-1:0] d, input logic last, input logic v);
    tb_in_data[k*DATA_W +: DATA_W] = d;
    tb_in_last[k]  = last;
    tb_in_valid[k] = v;
  endtask

  function automatic beat_t mk(input logic [DATA_W-1:0] d, input logic last, input int k);
    beat_t b;
    b.data = d;
    b.last = last;
    b.ch   = CH_W'(k);
    return b;
  endfunction

  task automatic add_pkt(input int k, input int len);
    for (int b = 0; b < len; b++) chq[k].push_back(mk(8'($urandom), b == len - 1, k));
  endtask

  // Reference: each arbitration picks among channels that still hold packets
  task automatic build_expected(input bit fixed_prio);
    int    mi[N_CH];
    int    w;
    int    c;
    beat_t b;
    for (int k = 0; k < N_CH; k++) mi[k] = 0;
    forever begin
      w = -1;
      for (int i = 0; i < N_CH; i++) begin
        c = fixed_prio ? i : (model_rr + i) % N_CH;
        if (w < 0 && mi[c] < chq[c].size()) w = c;
      end
      if (w < 0) break;
      do begin
        b = chq[w][mi[w]];
        mi[w]++;
        exp_q.push_back(b);
      end while (!b.last);
      if (!fixed_prio) model_rr = (w + 1) % N_CH;
    end
  endtask

  // Feeds every channel queue; first beats are always offered, later beats may gap
  task automatic run_stream(input int gap_pct, input int rdy_pct, input int max_cyc);
    int              idx[N_CH];
    logic [N_CH-1:0] fire;
    int              n;
    bit              done;
    bit              first;
    beat_t           b;
    ch_log.delete();
    cyc_log.delete();
    build_expected(sel);
    for (int k = 0; k < N_CH; k++) idx[k] = 0;
    n = 0;
    forever begin
      done = 1'b1;
      for (int k = 0; k < N_CH; k++) begin
        if (idx[k] < chq[k].size()) begin
          done  = 1'b0;
          b     = chq[k][idx[k]];
          first = (idx[k] == 0) || chq[k][idx[k]-1].last;
          drive(k, b.data, b.last, first ? 1'b1 : ($urandom_range(99) >= gap_pct));
        end else begin
          tb_in_valid[k] = 1'b0;
        end
      end
      tb_out_ready = ($urandom_range(99) < rdy_pct);
      if (done && exp_q.size() == 0) break;
      if (n >= max_cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL stream_timeout: got %0d beats pending, required 0", exp_q.size());
        break;
      end
      @(negedge clk);
      fire = tb_in_valid & m_in_ready;
      tick;
      n++;
      for (int k = 0; k < N_CH; k++) if (fire[k]) idx[k]++;
    end
    tb_in_valid = '0;
    for (int k = 0; k < N_CH; k++) chq[k].delete();
    check("stream_sb_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    sel = 1'b0;
    do_reset;
    check("rst_out_valid", 64'(m_out_valid), 64'd0);
    check("rst_busy", 64'(m_busy), 64'd0);
    check("rst_in_ready", 64'(m_in_ready), 64'd0);
    check("rst_out_data", 64'(m_out_data), 64'd0);
    check("rst_out_last", 64'(m_out_last), 64'd0);
    check("rst_out_ch", 64'(m_out_ch), 64'd0);

    // Round-robin, ch1 and ch3 two-beat packets
    add_pkt(1, 2);
    add_pkt(3, 2);
    run_stream(0, 100, 200);
    check("rr2_n", 64'(ch_log.size()), 64'd4);
    if (ch_log.size() == 4) begin
      check("rr2_ch0", 64'(ch_log[0]), 64'd1);
      check("rr2_ch1", 64'(ch_log[1]), 64'd1);
      check("rr2_ch2", 64'(ch_log[2]), 64'd3);
      check("rr2_ch3", 64'(ch_log[3]), 64'd3);
    end
    // Pointer wrapped to 0: ch0 must beat ch2
    add_pkt(2, 1);
    add_pkt(0, 1);
    run_stream(0, 100, 200);
    if (ch_log.size() > 0) check("rr_ptr_wrap", 64'(ch_log[0]), 64'd0);
    else check("rr_ptr_wrap_n", 64'(ch_log.size()), 64'd2);

    // Round-robin, all channels one-beat packets back to back
    do_reset;
    for (int k = 0; k < N_CH; k++) begin
      add_pkt(k, 1);
      add_pkt(k, 1);
    end
    run_stream(0, 100, 200);
    check("rr4_n", 64'(ch_log.size()), 64'd8);
    if (ch_log.size() == 8) begin
      for (int i = 0; i < 5; i++) check($sformatf("rr4_order%0d", i), 64'(ch_log[i]), 64'(i % 4));
      for (int i = 1; i < 8; i++)
        check($sformatf("rr4_gap%0d", i), 64'(cyc_log[i] - cyc_log[i-1]), 64'd2);
    end

    // Fixed priority: ch0 starves ch2
    sel = 1'b1;
    do_reset;
    for (int i = 0; i < 6; i++) add_pkt(0, 1);
    add_pkt(2, 1);
    add_pkt(2, 1);
    run_stream(0, 100, 200);
    check("fp_n", 64'(ch_log.size()), 64'd8);
    if (ch_log.size() == 8) begin
      for (int i = 0; i < 6; i++) check($sformatf("fp_ch0_%0d", i), 64'(ch_log[i]), 64'd0);
    end

    // Output stall with 0xA5 held
    sel = 1'b0;
    do_reset;
    exp_q.push_back(mk(8'hA5, 1'b0, 2));
    exp_q.push_back(mk(8'h5A, 1'b1, 2));
    drive(2, 8'hA5, 1'b0, 1'b1);
    tick;
    tick;
    drive(2, 8'h5A, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(m_out_valid), 64'd1);
      check("stall_data", 64'(m_out_data), 64'hA5);
      check("stall_in_ready", 64'(m_in_ready), 64'd0);
      check("stall_busy", 64'(m_busy), 64'd1);
      tick;
    end
    tb_out_ready = 1'b1;
    tick;
    tb_in_valid[2] = 1'b0;
    tick;
    tick;
    check("stall_sb_empty", 64'(exp_q.size()), 64'd0);
    check("stall_beats", 64'(ch_log.size()), 64'd2);
    check("stall_drained", 64'(m_out_valid), 64'd0);

    // Granted channel pauses mid-packet while ch0 requests
    do_reset;
    tb_out_ready = 1'b1;
    for (int b = 0; b < 4; b++) exp_q.push_back(mk(8'(8'h10 + b), b == 3, 1));
    exp_q.push_back(mk(8'h20, 1'b1, 0));
    drive(1, 8'h10, 1'b0, 1'b1);
    tick;
    drive(0, 8'h20, 1'b1, 1'b1);
    tick;
    drive(1, 8'h11, 1'b0, 1'b1);
    tick;
    tb_in_valid[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("gap_busy", 64'(m_busy), 64'd1);
      check("gap_in_ready", 64'(m_in_ready), 64'b0010);
      tick;
    end
    drive(1, 8'h12, 1'b0, 1'b1);
    tick;
    drive(1, 8'h13, 1'b1, 1'b1);
    tick;
    tb_in_valid[1] = 1'b0;
    tick;
    tick;
    tb_in_valid[0] = 1'b0;
    tick;
    tick;
    check("gap_sb_empty", 64'(exp_q.size()), 64'd0);

    // Reset during beat 2 of 4, pointer previously advanced to 3
    do_reset;
    tb_out_ready = 1'b1;
    exp_q.push_back(mk(8'h42, 1'b1, 2));
    drive(2, 8'h42, 1'b1, 1'b1);
    tick;
    tick;
    tb_in_valid[2] = 1'b0;
    drive(1, 8'h30, 1'b0, 1'b1);
    tick;
    tick;
    drive(1, 8'h31, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_in_ready", 64'(m_in_ready), 64'd0);
    tick;
    rst = 1'b0;
    tb_in_valid = '0;
    check("mrst_out_valid", 64'(m_out_valid), 64'd0);
    check("mrst_busy", 64'(m_busy), 64'd0);
    exp_q.push_back(mk(8'h51, 1'b1, 1));
    exp_q.push_back(mk(8'h53, 1'b1, 3));
    drive(1, 8'h51, 1'b1, 1'b1);
    drive(3, 8'h53, 1'b1, 1'b1);
    tick;
    tick;
    tb_in_valid[1] = 1'b0;
    tick;
    tick;
    tb_in_valid[3] = 1'b0;
    tick;
    tick;
    check("mrst_sb_empty", 64'(exp_q.size()), 64'd0);

    // Randomised traffic on both arbitration modes
    for (int m = 0; m < 2; m++) begin
      sel = m[0];
      do_reset;
      for (int r = 0; r < 4; r++) begin
        for (int k = 0; k < N_CH; k++) begin
          int np;
          np = $urandom_range(3);
          for (int p = 0; p < np; p++) add_pkt(k, $urandom_range(1, 4));
        end
        run_stream(30, 70, 3000);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
